demux128_reg_n: RTL and testbench
=================================

Name: demux128_reg_n

Overview:
- Write-side counterpart of the 128:1 read mux: a 1-to-128 registered demultiplexer that steers one n-bit write into one of 128 storage registers.
- Decode is two-level: sel_i[6:5] picks one of 4 groups and sel_i[4:0] picks one of 32 entries in that group.
- Has a valid/ready write handshake, a one-hot write strobe, and a multi-cycle group-by-group clear.
- data_o feeds the 128:1 read mux directly; together they form a 128-entry register bank.

Parameters:
- n, 4, data width of each entry.
- address, 7, select width; fixed, 2**address = 128 entries.
- gr, 4, number of groups (2**address/32).
- m, 32, entries per group.
- s, 2, group-select width (log2(gr)).

Ports:
- clk_i  input  1  single clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- valid_i  input  1  write request valid.
- ready_o  output  1  block can accept a write this cycle.
- sel_i  input  7  target entry index, 0..127.
- data_i  input  n  write data.
- clr_i  input  1  request to clear all 128 entries; a level sampled in IDLE.
- data_o  output  n x 128  unpacked array [0:127] of stored entries.
- wr_strobe_o  output  128  one-hot pulse marking the entry written this cycle.
- busy_o  output  1  clear in progress or a write in flight.

Behaviour:
- Reset (rst_ni=0, takes effect immediately, no clock needed):
  - all data_o entries = 0, wr_strobe_o = 0, ready_o = 0, busy_o = 0;
  - stage-1 valid = 0, FSM = IDLE, group counter = 0.
  - ready_o rises combinationally once rst_ni=1 and FSM=IDLE.
- FSM states: IDLE, DRAIN, CLR.
  - IDLE: ready_o = !clr_i. If clr_i=1, go to DRAIN when stage-1 holds a write, otherwise to CLR with counter=0.
  - DRAIN: ready_o = 0. Stays exactly one cycle, letting the in-flight write retire, then goes to CLR with counter=0.
  - CLR: ready_o = 0. Each cycle zeroes all 32 entries of group counter (one-hot group clear, no strobes). Counter increments; at counter=3 the FSM returns to IDLE after that cycle.
  - A clear therefore takes 4 cycles, or 5 with a drain.
- Accept: a write is accepted on an edge where valid_i && ready_o. At that edge stage 1 captures the group decode (one-hot 4 of sel_i[6:5]), sel_i[4:0], data_i, and sets valid.
- Commit: on the next edge (E+1), if stage-1 valid:
  - the entry data_o[sel] gets data;
  - wr_strobe_o has bit sel set for the cycle after E+1, and is zero otherwise.
  - Write latency is 2 edges from acceptance to data_o updated.
- Throughput: one write per cycle. Back-to-back writes to the same index commit in order, so the last one wins.
- Simultaneous clr_i and valid_i in IDLE: clear has priority. ready_o=0, so the write is not accepted and the source must hold it.
- A write accepted on the edge before clr_i rises always commits before the clear begins. Its value is then zeroed by the clear.
- clr_i deasserted during CLR is ignored; a clear always runs to completion. clr_i still high on return to IDLE starts another clear.
- Reset mid-clear or mid-write: everything returns to the reset values and in-flight writes are discarded.
- busy_o = (FSM != IDLE) || stage-1 valid.
- Unwritten entries hold their value indefinitely.
- sel_i is only sampled when a write is accepted; there are no out-of-range cases.

Decomposition:
- Package demux_pkg:
  - localparams ADDR_W=7, GR=4, M=32, S=2;
  - enum state_t {IDLE, DRAIN, CLR};
  - a function for the 2-to-4 one-hot decode.
- Sub-module demux32_reg_n (parameter n): one group of 32 registers.
  - Inputs: clk_i, rst_ni, we (group hit from stage 1), a 5-bit index, data, and clr (group clear).
  - Outputs: data_o[0:31] and a 32-bit strobe.
  - Clear takes priority over we inside a group, though the FSM never asserts both at once.
- Top level instantiates 4 copies with a generate loop and concatenates their outputs. Entry index = group*32 + index.

Test Plan:
- Reset/idle: hold rst_ni=0 for 3 cycles, then release -> all 128 data_o=0, wr_strobe_o=0, ready_o=1, busy_o=0.
- Single write: valid_i=1, sel_i=7'd37, data_i=4'hA for one cycle -> two edges later data_o[37]=4'hA, wr_strobe_o=1<<37 for exactly one cycle, all other entries still 0.
- Streaming: write sel 0,31,32,127 with data 1,2,3,4 on consecutive cycles -> each commits 2 edges after acceptance; strobes appear on 4 consecutive cycles; a final write of 4'hF to sel 32 reads back as 4'hF.
- Clear with drain: write sel 100=4'h5, and assert clr_i on the cycle after acceptance -> entry 100 becomes 5, then ready_o=0 for 5 cycles, groups clear in order 0,1,2,3, all entries end at 0, ready_o returns to 1.
- Priority: assert valid_i and clr_i together in IDLE -> ready_o=0, no write commits, 4-cycle clear, and the write is accepted only after the return to IDLE.
- Async reset mid-clear: pull rst_ni low during CLR with counter=2, between clock edges -> outputs reset immediately, FSM returns to IDLE, previously written entries in groups 2 and 3 read 0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and constants for the 128-entry registered write demultiplexer.
// Entry index = group * M + index-within-group.
package demux_pkg;

  localparam int ADDR_W = 7;
  localparam int GR     = 4;
  localparam int M      = 32;
  localparam int S      = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLR   = 2'd2
  } state_t;

  function automatic logic [GR-1:0] onehot4(input logic [S-1:0] sel);
    onehot4      = '0;
    onehot4[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/demux32_reg_n.sv
// One group of 32 n-bit storage registers with an indexed write port,
// a one-cycle write strobe and a whole-group synchronous clear.
module demux32_reg_n
  import demux_pkg::*;
#(
  parameter int n = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         we_i,
  input  logic [4:0]   idx_i,
  input  logic [n-1:0] data_i,
  input  logic         clr_i,
  output logic [n-1:0] data_o [0:M-1],
  output logic [M-1:0] strobe_o
);

  logic [n-1:0] r_data [0:M-1];
  logic [M-1:0] r_strobe;

  // Clear wins over a write; a cleared group never raises a strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < M; i++) r_data[i] <= '0;
      r_strobe <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < M; i++) r_data[i] <= '0;
      r_strobe <= '0;
    end else begin
      r_strobe <= we_i ? (M'(1) << idx_i) : '0;
      if (we_i) r_data[idx_i] <= data_i;
    end
  end

  assign data_o   = r_data;
  assign strobe_o = r_strobe;

endmodule

// File: rtl/demux128_reg_n.sv
// 1-to-128 registered write demultiplexer: stage-1 capture of the decoded write,
// commit one edge later, plus a group-by-group clear sequenced by a small FSM.
module demux128_reg_n
  import demux_pkg::*;
#(
  parameter int n = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [ADDR_W-1:0] sel_i,
  input  logic [n-1:0]      data_i,
  input  logic              clr_i,
  output logic [n-1:0]      data_o [0:GR*M-1],
  output logic [GR*M-1:0]   wr_strobe_o,
  output logic              busy_o,
  output logic [1:0]        dbg_state_o
);

  state_t          r_state;
  logic [S-1:0]    r_cnt;
  logic            r_s1_valid;
  logic [GR-1:0]   r_s1_grp;
  logic [4:0]      r_s1_idx;
  logic [n-1:0]    r_s1_data;
  logic            w_accept;
  logic [GR-1:0]   w_grp_clr;

  // Handshake: a write transfers on a rising edge where valid_i && ready_o.
  // ready_o is low during reset, outside IDLE, and whenever clr_i is high,
  // so a source must hold valid_i/sel_i/data_i stable until it sees ready_o.
  assign ready_o     = rst_ni && (r_state == IDLE) && !clr_i;
  assign w_accept    = valid_i && ready_o;
  assign busy_o      = (r_state != IDLE) || r_s1_valid;
  assign dbg_state_o = r_state;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (clr_i) begin
            r_state <= r_s1_valid ? DRAIN : CLR;
            r_cnt   <= '0;
          end
        end
        DRAIN: begin
          r_state <= CLR;
          r_cnt   <= '0;
        end
        CLR: begin
          r_cnt <= r_cnt + S'(1);
          if (r_cnt == S'(GR - 1)) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_valid <= 1'b0;
      r_s1_grp   <= '0;
      r_s1_idx   <= '0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_grp  <= onehot4(sel_i[6:5]);
        r_s1_idx  <= sel_i[4:0];
        r_s1_data <= data_i;
      end
    end
  end

  for (genvar g = 0; g < GR; g++) begin : g_grp
    logic [n-1:0] w_data [0:M-1];

    assign w_grp_clr[g] = (r_state == CLR) && (r_cnt == S'(g));

    demux32_reg_n #(.n(n)) u_grp (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .we_i     (r_s1_valid && r_s1_grp[g]),
      .idx_i    (r_s1_idx),
      .data_i   (r_s1_data),
      .clr_i    (w_grp_clr[g]),
      .data_o   (w_data),
      .strobe_o (wr_strobe_o[g*M +: M])
    );

    for (genvar i = 0; i < M; i++) begin : g_ent
      assign data_o[g*M + i] = w_data[i];
    end
  end

endmodule

// File: tb/tb_demux128_reg_n.sv
// Directed bench for demux128_reg_n: writes are pushed to an expected queue,
// a negedge monitor pops one entry per observed write strobe.
module tb_demux128_reg_n;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_CLR   = 2'd2;

  logic         clk_i;
  logic         rst_ni;
  logic         valid_i;
  logic         ready_o;
  logic [6:0]   sel_i;
  logic [3:0]   data_i;
  logic         clr_i;
  logic [3:0]   data_o [0:127];
  logic [127:0] wr_strobe_o;
  logic         busy_o;
  logic [1:0]   dbg_state_o;

  logic [10:0]  exp_q[$];
  logic [3:0]   model [0:127];
  int           n_checks = 0;
  int           n_fail   = 0;

  demux128_reg_n #(.n(4)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .sel_i       (sel_i),
    .data_i      (data_i),
    .clr_i       (clr_i),
    .data_o      (data_o),
    .wr_strobe_o (wr_strobe_o),
    .busy_o      (busy_o),
    .dbg_state_o (dbg_state_o)
  );

  // clock / reset
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  // checking helpers
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name);
    int bad = -1;
    for (int i = 0; i < 128; i++)
      if (data_o[i] !== model[i] && bad < 0) bad = i;
    n_checks++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: entry %0d got %0h expected %0h", name, bad, data_o[bad], model[bad]);
    end
  endtask

  task automatic model_clear_group(input int g);
    for (int i = 0; i < 32; i++) model[g*32 + i] = 4'h0;
  endtask

  // driver: leaves valid_i high on return (at a negedge) so writes can stream
  task automatic write(input logic [6:0] s, input logic [3:0] d, output int waited);
    waited  = 0;
    valid_i = 1'b1;
    sel_i   = s;
    data_i  = d;
    #1;
    while (!ready_o && waited < 50) begin
      @(negedge clk_i);
      #1;
      waited++;
    end
    n_checks++;
    if (!ready_o) begin
      n_fail++;
      $display("FAIL write_accept_timeout: got ready_o=0 expected 1 within 50 cycles");
      valid_i = 1'b0;
    end else begin
      exp_q.push_back({s, d});
      model[s] = d;
      @(posedge clk_i);
      @(negedge clk_i);
    end
  endtask

  task automatic idle(input int k);
    valid_i = 1'b0;
    repeat (k) @(negedge clk_i);
  endtask

  // monitor / scoreboard
  always @(negedge clk_i) begin
    logic [10:0]  e;
    logic [127:0] one;
    if (rst_ni && wr_strobe_o != '0) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: got %0h expected none", wr_strobe_o);
      end else begin
        e   = exp_q.pop_front();
        one = 128'd1;
        if (wr_strobe_o !== (one << e[10:4]) || data_o[e[10:4]] !== e[3:0]) begin
          n_fail++;
          $display("FAIL commit: got strobe %0h data %0h expected strobe bit %0d data %0h",
                   wr_strobe_o, data_o[e[10:4]], e[10:4], e[3:0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    int w;
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    clr_i   = 1'b0;
    sel_i   = '0;
    data_i  = '0;
    for (int i = 0; i < 128; i++) model[i] = 4'h0;

    // reset / idle
    repeat (3) @(negedge clk_i);
    #1;
    check("reset_ready", 128'(ready_o), 128'd0);
    check("reset_busy", 128'(busy_o), 128'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("idle_ready", 128'(ready_o), 128'd1);
    check("idle_busy", 128'(busy_o), 128'd0);
    check("idle_strobe", wr_strobe_o, 128'd0);
    check("idle_state", 128'(dbg_state_o), 128'(ST_IDLE));
    check_all("reset_data");

    // single write with latency check
    @(negedge clk_i);
    write(7'd37, 4'hA, w);
    valid_i = 1'b0;
    #1;
    check("single_busy_inflight", 128'(busy_o), 128'd1);
    check("single_not_yet", 128'(data_o[37]), 128'h0);
    check("single_no_strobe_yet", wr_strobe_o, 128'd0);
    @(negedge clk_i);
    check("single_data", 128'(data_o[37]), 128'hA);
    check("single_strobe", wr_strobe_o, 128'd1 << 37);
    @(negedge clk_i);
    check("single_strobe_one_cycle", wr_strobe_o, 128'd0);
    check_all("single_all");

    // streaming, boundary indices, last write wins
    write(7'd0, 4'h1, w);
    write(7'd31, 4'h2, w);
    write(7'd32, 4'h3, w);
    write(7'd127, 4'h4, w);
    write(7'd32, 4'hF, w);
    idle(3);
    check("stream_32_last", 128'(data_o[32]), 128'hF);
    check_all("stream_all");

    // clear with drain, groups cleared in order
    write(7'd70, 4'h6, w);
    write(7'd100, 4'h5, w);
    valid_i = 1'b0;
    clr_i   = 1'b1;
    #1;
    check("drain_ready_clr", 128'(ready_o), 128'd0);
    check("drain_busy", 128'(busy_o), 128'd1);
    @(negedge clk_i);
    clr_i = 1'b0;
    #1;
    check("drain_state", 128'(dbg_state_o), 128'(ST_DRAIN));
    check("drain_ready", 128'(ready_o), 128'd0);
    check("drain_e100", 128'(data_o[100]), 128'h5);
    @(negedge clk_i);
    check("clr_state", 128'(dbg_state_o), 128'(ST_CLR));
    check_all("clr_before_group0");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      model_clear_group(k);
      check_all($sformatf("clr_group%0d", k));
      check($sformatf("clr_ready_after_group%0d", k), 128'(ready_o), (k == 3) ? 128'd1 : 128'd0);
    end
    check("clr_done_busy", 128'(busy_o), 128'd0);

    // clear has priority over a simultaneous write
    valid_i = 1'b1;
    sel_i   = 7'd5;
    data_i  = 4'h7;
    clr_i   = 1'b1;
    #1;
    check("prio_ready", 128'(ready_o), 128'd0);
    @(negedge clk_i);
    clr_i = 1'b0;
    #1;
    check("prio_state", 128'(dbg_state_o), 128'(ST_CLR));
    for (int i = 0; i < 128; i++) model[i] = 4'h0;
    write(7'd5, 4'h7, w);
    check("prio_wait_cycles", 128'(w), 128'd4);
    idle(2);
    check_all("prio_after");

    // async reset in the middle of a clear
    write(7'd70, 4'h9, w);
    write(7'd120, 4'h3, w);
    idle(2);
    clr_i = 1'b1;
    @(negedge clk_i);
    clr_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    model_clear_group(0);
    model_clear_group(1);
    check("midclr_state", 128'(dbg_state_o), 128'(ST_CLR));
    check_all("midclr_partial");
    #1;
    rst_ni = 1'b0;
    #1;
    for (int i = 0; i < 128; i++) model[i] = 4'h0;
    check("rst_mid_ready", 128'(ready_o), 128'd0);
    check("rst_mid_busy", 128'(busy_o), 128'd0);
    check("rst_mid_state", 128'(dbg_state_o), 128'(ST_IDLE));
    check("rst_mid_strobe", wr_strobe_o, 128'd0);
    check("rst_mid_e70", 128'(data_o[70]), 128'h0);
    check_all("rst_mid_all");
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("rst_release_ready", 128'(ready_o), 128'd1);
    idle(2);

    check("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
